register_bank_param: RTL and testbench
======================================

REGISTER_BANK_PARAM -- requirements
Module: register_bank_param

Interface
REQ-001 SHALL provide parameters (name, default, meaning), one per line:
  DATA_W  32  register width in bits
  ADDR_W  5  address width; DEPTH = 2**ADDR_W registers
  NUM_RD  4  number of read ports
  ZERO_REG  1  1: register 0 reads 0 and ignores writes
  BYPASS  1  1: same-cycle write data forwarded to matching read ports
REQ-002 SHALL provide ports (name, direction, width, meaning), one per line:
  clock  in  1  single clock, rising edge
  reset  in  1  synchronous, active-high; starts clear sequence
  wr_en  in  1  write request
  wr_addr  in  ADDR_W  write address
  wr_data  in  DATA_W  write data
  mark_en  in  1  set pending bit (destination issued)
  mark_addr  in  ADDR_W  address to mark pending
  rd_addr  in  NUM_RD*ADDR_W  packed read addresses; port i = bits [i*ADDR_W +: ADDR_W]
  rd_data  out  NUM_RD*DATA_W  packed read data, combinational
  rd_pending  out  NUM_RD  pending bit of each read address, combinational
  busy  out  1  clear sequence in progress
  wr_drop  out  1  registered one-cycle pulse: a write was discarded
REQ-003 SHALL use one clock and a synchronous, active-high reset on the ports named clock and reset; no other clock or asynchronous input.

Function
REQ-004 Storage SHALL be DEPTH x DATA_W; a write is accepted when wr_en=1, busy=0 and NOT(ZERO_REG=1 and wr_addr=0), committing wr_data on the rising edge.
REQ-005 Clear sequencer SHALL have two states: CLEAR and IDLE; a clear counter of ADDR_W+1 bits.
REQ-006 In CLEAR, each cycle SHALL write 0 to the register at the counter and increment; the transition to IDLE SHALL occur on the edge that clears address DEPTH-1.
REQ-007 busy SHALL be 1 exactly while in CLEAR.
REQ-008 While busy=1, all rd_data SHALL read 0 and all rd_pending SHALL read 0.
REQ-009 wr_en=1 while busy=1 SHALL be discarded, with wr_drop=1 on the following cycle; a write to address 0 with ZERO_REG=1 is ignored silently (no wr_drop).
REQ-010 With ZERO_REG=1, any read port addressing 0 SHALL return 0 regardless of storage or bypass.
REQ-011 With BYPASS=1 and an accepted write, a read port whose address equals wr_addr SHALL return wr_data in the same cycle; with BYPASS=0 it SHALL return the old value until after the edge.
REQ-012 Simultaneous reads of the same address on several ports SHALL all return identical data.
REQ-013 Scoreboard: mark_en=1 with busy=0 SHALL set pending[mark_addr] at the edge (never for address 0 when ZERO_REG=1).
REQ-014 An accepted write SHALL clear pending[wr_addr] at the edge.
REQ-015 mark_en and an accepted write to the same address in the same cycle SHALL leave the pending bit set (mark wins).
REQ-016 rd_pending SHALL reflect the registered pending bits; no bypass of same-cycle mark or clear.
REQ-017 mark_en while busy=1 SHALL be ignored.
REQ-018 Parameter legality: ADDR_W >= 1, DATA_W >= 1, NUM_RD >= 1; the wrap of the clear counter SHALL never occur (the counter stops at DEPTH).

Reset
REQ-019 While reset=1 at an edge: state becomes CLEAR, counter becomes 0, all pending bits become 0, and wr_drop becomes 0.
REQ-020 After the reset edge: busy=1; rd_data=0; rd_pending=0; wr_drop=0.
REQ-021 The clear SHALL start on the first edge with reset=0; busy SHALL fall after exactly DEPTH such edges (32 at defaults).
REQ-022 Reset asserted mid-clear or mid-operation SHALL restart the sequence from counter 0; the storage contents of registers not yet cleared are don't-care but SHALL never be visible (REQ-008).

Verification
REQ-023 Reset 1 cycle, then idle -> busy=1 for 32 edges, then 0; reading addresses 0..31 afterwards -> all 0.
REQ-024 busy=0; write 0xDEADBEEF to address 7 while rd_addr port0=7 -> port0 shows 0xDEADBEEF in the same cycle (BYPASS=1) and in the next cycle; BYPASS=0 -> old value 0, then 0xDEADBEEF.
REQ-025 Write 0x12345678 to address 0 (ZERO_REG=1) -> port reading 0 stays 0; wr_drop stays 0.
REQ-026 Write during busy (cycle 5 of clear) -> wr_drop=1 for one cycle; after clear, the target reads 0.
REQ-027 mark address 3; next cycle rd_pending for 3 = 1; write address 3 -> pending 0 after the edge; mark plus write on 9 in the same cycle -> pending[9]=1.
REQ-028 Reset asserted at clear cycle 10, held 1 cycle -> busy stays 1 for a further 32 edges; pending all 0.

Source files
------------

// File: rtl/register_bank_param.sv
// Parameterised register file with a pending-bit scoreboard, multi-port combinational reads and a post-reset clear sweep.
// Reads have zero latency (optional same-cycle write bypass); writes and marks arriving during the clear sweep are discarded, and discarded writes are flagged on wr_drop.
module register_bank_param #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 4,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       wr_en,
    input  logic [ADDR_W-1:0]          wr_addr,
    input  logic [DATA_W-1:0]          wr_data,
    input  logic                       mark_en,
    input  logic [ADDR_W-1:0]          mark_addr,
    input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
    output logic [NUM_RD*DATA_W-1:0]   rd_data,
    output logic [NUM_RD-1:0]          rd_pending,
    output logic                       busy,
    output logic                       wr_drop
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W:0] CLR_LAST = (ADDR_W+1)'(DEPTH - 1);

    typedef enum logic {CLEAR, IDLE} state_t;

    state_t             state_q, state_d;
    logic [ADDR_W:0]    clr_cnt;
    logic [DATA_W-1:0]  mem [DEPTH];
    logic [DEPTH-1:0]   pending;
    logic               wr_zero;
    logic               wr_accept;
    logic               mark_ok;

    assign busy      = (state_q == CLEAR);
    assign wr_zero   = (ZERO_REG != 0) && (wr_addr == '0);
    assign wr_accept = wr_en && !busy && !wr_zero;
    assign mark_ok   = mark_en && !busy && !((ZERO_REG != 0) && (mark_addr == '0));

    always_comb begin
        state_d = state_q;
        if (state_q == CLEAR && clr_cnt == CLR_LAST) begin
            state_d = IDLE;
        end
    end

    // Counter advances only while clearing, so it parks at DEPTH and never wraps.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= CLEAR;
            clr_cnt <= '0;
            pending <= '0;
            wr_drop <= 1'b0;
        end else begin
            state_q <= state_d;
            wr_drop <= wr_en && busy;
            if (busy) begin
                clr_cnt <= clr_cnt + 1'b1;
            end
            if (wr_accept) begin
                pending[wr_addr] <= 1'b0;
            end
            // Applied after the write-clear so a same-address mark wins.
            if (mark_ok) begin
                pending[mark_addr] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            if (busy) begin
                mem[clr_cnt[ADDR_W-1:0]] <= '0;
            end else if (wr_accept) begin
                mem[wr_addr] <= wr_data;
            end
        end
    end

    for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        logic              hit_zero;
        logic              hit_byp;

        assign ra       = rd_addr[g*ADDR_W +: ADDR_W];
        assign hit_zero = (ZERO_REG != 0) && (ra == '0);
        assign hit_byp  = (BYPASS != 0) && wr_accept && (wr_addr == ra);

        assign rd_data[g*DATA_W +: DATA_W] = (busy || hit_zero) ? '0 :
                                             hit_byp            ? wr_data :
                                                                  mem[ra];
        assign rd_pending[g] = !busy && pending[ra];
    end

endmodule

// File: tb/tb_register_bank_param.sv
// Directed bench for register_bank_param: stimulus queues expectations per cycle, a negedge monitor pops and compares.
module tb_register_bank_param;

    logic         clock;
    logic         reset;
    logic         wr_en;
    logic [4:0]   wr_addr;
    logic [31:0]  wr_data;
    logic         mark_en;
    logic [4:0]   mark_addr;
    logic [19:0]  rd_addr;
    logic [127:0] rd_data_a, rd_data_b;
    logic [3:0]   rd_pending_a, rd_pending_b;
    logic         busy_a, busy_b;
    logic         wr_drop_a, wr_drop_b;

    register_bank_param #(.BYPASS(1)) dut_a (
        .clock(clock), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .mark_en(mark_en), .mark_addr(mark_addr), .rd_addr(rd_addr), .rd_data(rd_data_a),
        .rd_pending(rd_pending_a), .busy(busy_a), .wr_drop(wr_drop_a)
    );

    register_bank_param #(.BYPASS(0)) dut_b (
        .clock(clock), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .mark_en(mark_en), .mark_addr(mark_addr), .rd_addr(rd_addr), .rd_data(rd_data_b),
        .rd_pending(rd_pending_b), .busy(busy_b), .wr_drop(wr_drop_b)
    );

    typedef struct packed {
        int          cyc;
        int          kind;
        int          idx;
        logic [31:0] exp;
        logic [95:0] name;
    } exp_t;

    localparam int K_BUSY = 0, K_DROP = 1, K_DATA = 2, K_PEND = 3, K_DATA_B = 4, K_BUSY_B = 5;

    exp_t sbq[$];
    int   cyc   = 0;
    int   tests = 0;
    int   fails = 0;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    function automatic logic [31:0] actual(int kind, int idx);
        case (kind)
            K_BUSY:   return {31'b0, busy_a};
            K_DROP:   return {31'b0, wr_drop_a};
            K_DATA:   return rd_data_a[idx*32 +: 32];
            K_PEND:   return {31'b0, rd_pending_a[idx]};
            K_DATA_B: return rd_data_b[idx*32 +: 32];
            K_BUSY_B: return {31'b0, busy_b};
            default:  return '0;
        endcase
    endfunction

    always @(negedge clock) begin
        exp_t        e;
        logic [31:0] act;
        while (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
            e = sbq.pop_front();
            tests++;
            if (e.cyc != cyc) begin
                fails++;
                $display("FAIL %s: check for cycle %0d not sampled (now %0d)", e.name, e.cyc, cyc);
            end else begin
                act = actual(e.kind, e.idx);
                if (act !== e.exp) begin
                    fails++;
                    $display("FAIL %s: port %0d got %h, expected %h (cycle %0d)", e.name, e.idx, act, e.exp, cyc);
                end
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input int kind, input int idx, input logic [31:0] v, input logic [95:0] nm);
        exp_t e;
        e.cyc  = cyc;
        e.kind = kind;
        e.idx  = idx;
        e.exp  = v;
        e.name = nm;
        sbq.push_back(e);
    endtask

    task automatic set_rd(input int p, input logic [4:0] a);
        rd_addr[p*5 +: 5] = a;
    endtask

    initial begin
        exp_t e;
        reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        mark_en = 1'b0; mark_addr = '0; rd_addr = '0;

        // Reset edge, then clear sweep with a dropped write/mark at window 4.
        step();
        reset = 1'b0;
        set_rd(0, 5'd5);
        chk(K_BUSY,   0, 1, "rst_busy");
        chk(K_BUSY_B, 0, 1, "rst_busy_b");
        chk(K_DROP,   0, 0, "rst_drop");
        chk(K_DATA,   0, 0, "rst_rdata");
        chk(K_PEND,   0, 0, "rst_pend");
        for (int w = 1; w <= 32; w++) begin
            step();
            wr_en = 1'b0; mark_en = 1'b0;
            if (w == 4) begin
                wr_en = 1'b1; wr_addr = 5'd2; wr_data = 32'hAAAA5555;
                mark_en = 1'b1; mark_addr = 5'd2;
                set_rd(1, 5'd2);
                chk(K_DATA, 1, 0, "busy_mask");
            end
            chk(K_BUSY, 0, (w < 32) ? 32'd1 : 32'd0, "clr_busy");
            if (w >= 4 && w <= 6) chk(K_DROP, 0, (w == 5) ? 32'd1 : 32'd0, "clr_drop");
        end
        chk(K_BUSY_B, 0, 0, "clr_busy_b");

        for (int b = 0; b < 8; b++) begin
            step();
            for (int p = 0; p < 4; p++) begin
                set_rd(p, 5'(b*4 + p));
            end
            for (int p = 0; p < 4; p++) begin
                chk(K_DATA, p, 0, "sweep_data");
                chk(K_PEND, p, 0, "sweep_pend");
            end
        end

        // Same-cycle bypass versus no-bypass, and identical multi-port reads.
        step();
        wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'hDEADBEEF;
        set_rd(0, 5'd7); set_rd(1, 5'd7); set_rd(2, 5'd7); set_rd(3, 5'd8);
        chk(K_DATA,   0, 32'hDEADBEEF, "byp_p0");
        chk(K_DATA,   1, 32'hDEADBEEF, "byp_p1");
        chk(K_DATA,   3, 0,            "byp_other");
        chk(K_DATA_B, 0, 0,            "nobyp_p0");
        step();
        wr_en = 1'b0;
        chk(K_DATA,   0, 32'hDEADBEEF, "after_p0");
        chk(K_DATA,   2, 32'hDEADBEEF, "after_p2");
        chk(K_DATA_B, 0, 32'hDEADBEEF, "after_b_p0");
        chk(K_DROP,   0, 0,            "wr_nodrop");

        // Writes to register 0 are ignored without a drop pulse.
        step();
        wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'h12345678;
        set_rd(0, 5'd0);
        chk(K_DATA,   0, 0, "zero_byp");
        chk(K_DATA_B, 0, 0, "zero_byp_b");
        step();
        wr_en = 1'b0;
        chk(K_DATA,   0, 0, "zero_after");
        chk(K_DATA_B, 0, 0, "zero_after_b");
        chk(K_DROP,   0, 0, "zero_nodrop");

        // Pending scoreboard: set, hold, clear by write, mark wins, addr 0.
        step();
        mark_en = 1'b1; mark_addr = 5'd3;
        set_rd(0, 5'd3);
        chk(K_PEND, 0, 0, "mark_nobyp");
        step();
        mark_en = 1'b0;
        chk(K_PEND, 0, 1, "mark_set");
        step();
        wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h00000033;
        chk(K_PEND, 0, 1,     "pend_hold");
        chk(K_DATA, 0, 32'h33, "w3_byp");
        step();
        wr_en = 1'b0;
        chk(K_PEND,   0, 0,     "pend_clr");
        chk(K_DATA_B, 0, 32'h33, "w3_b");
        step();
        wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h00000099;
        mark_en = 1'b1; mark_addr = 5'd9;
        set_rd(1, 5'd9);
        step();
        wr_en = 1'b0; mark_en = 1'b0;
        chk(K_PEND, 1, 1,     "mark_wins");
        chk(K_DATA, 1, 32'h99, "w9_data");
        step();
        mark_en = 1'b1; mark_addr = 5'd0;
        set_rd(0, 5'd0);
        step();
        mark_en = 1'b0;
        chk(K_PEND, 0, 0, "mark_zero");

        // Reset mid-clear restarts the full sweep.
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk(K_BUSY, 0, 1, "rst2_busy");
        chk(K_DROP, 0, 0, "rst2_drop");
        for (int w = 1; w <= 10; w++) begin
            step();
            chk(K_BUSY, 0, 1, "clr2_busy");
            if (w == 10) reset = 1'b1;
        end
        step();
        reset = 1'b0;
        chk(K_BUSY, 0, 1, "rst3_busy");
        chk(K_PEND, 1, 0, "rst3_pend");
        for (int w = 1; w <= 32; w++) begin
            step();
            chk(K_BUSY, 0, (w < 32) ? 32'd1 : 32'd0, "clr3_busy");
        end
        chk(K_BUSY_B, 0, 0, "clr3_busy_b");
        step();
        set_rd(0, 5'd7); set_rd(1, 5'd9); set_rd(2, 5'd3); set_rd(3, 5'd31);
        for (int p = 0; p < 4; p++) begin
            chk(K_DATA, p, 0, "post_data");
            chk(K_PEND, p, 0, "post_pend");
        end
        chk(K_DATA_B, 0, 0, "post_data_b");

        for (int k = 0; k < 20 && sbq.size() > 0; k++) step();
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            tests++;
            fails++;
            $display("FAIL %s: check for cycle %0d never sampled", e.name, e.cyc);
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
